lcd_cmd_engine: RTL and testbench

- Consumer end of the LCD memory-mapped output word: takes 32-bit LCD command/data words written by the core and drives a parallel HD44780-class character LCD with correctly timed write cycles.
- Sits between the load/store unit's LCD output register, which raises a one-cycle valid strobe on each store, and the board LCD pins.
- Optionally runs the power-on initialisation sequence itself, so software only issues data and cursor commands.

---
 rtl/lcd_cmd_engine.sv | 198 +++++++++++++++++++
 tb/tb_lcd_cmd_engine.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_engine.sv
// lcd_cmd_engine
//   Consumes 32-bit LCD command/data words from the core's LCD output register
//   and drives an HD44780-class character LCD with timed write cycles:
//   SETUP (RS/DATA settle), EN_HI (enable strobe), HOLD, then EXEC (busy wait).
//
//   Optional build macro LCD_INIT_EN: after power-up the engine issues the
//   init commands 0x38, 0x0C, 0x01, 0x06 itself before accepting any word.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   req_valid/ready word handshake, accepted when both are high on an edge
//   req_word        [31]=ON, [9]=RS, [7:0]=DATA, other bits ignored
//   busy            high whenever the engine is not idle
//   done            one-cycle pulse as a write's execution wait ends
//   lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data   LCD pins (lcd_rw fixed at 0)
module lcd_cmd_engine #(
  parameter int T_PWRUP_CYC = 750000,
  parameter int T_SETUP_CYC = 3,
  parameter int T_EN_CYC    = 12,
  parameter int T_HOLD_CYC  = 3,
  parameter int T_EXEC_CYC  = 2500,
  parameter int T_CLEAR_CYC = 82000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_word,
  output logic        busy,
  output logic        done,
  output logic        lcd_on,
  output logic        lcd_en,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic [7:0]  lcd_data
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX = imax(imax(imax(T_PWRUP_CYC, T_SETUP_CYC), imax(T_EN_CYC, T_HOLD_CYC)),
                              imax(T_EXEC_CYC, T_CLEAR_CYC));
  localparam int CW = $clog2(T_MAX) + 1;

  typedef enum logic [2:0] {
    PWRUP = 3'd0,
    IDLE  = 3'd1,
    SETUP = 3'd2,
    EN_HI = 3'd3,
    HOLD  = 3'd4,
    EXEC  = 3'd5
`ifdef LCD_INIT_EN
    , INIT_LOAD = 3'd6
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_ready_q, req_ready_d;
  logic          done_q, done_d;
  logic          lcd_on_q, lcd_on_d;
  logic          lcd_en_q, lcd_en_d;
  logic          lcd_rs_q, lcd_rs_d;
  logic [7:0]    lcd_data_q, lcd_data_d;

  logic hs, last, is_clear;
  logic unused_bits;

  // Only ON, RS and DATA are meaningful in a request word.
  assign unused_bits = ^{req_word[30:10], req_word[8]};

  assign hs       = req_valid && req_ready_q;
  assign last     = (cnt_q == '0);
  // Clear display / return home need the long execution wait.
  assign is_clear = !lcd_rs_q && (lcd_data_q inside {8'h01, 8'h02, 8'h03});

`ifdef LCD_INIT_EN
  logic [1:0] idx_q, idx_d;

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;  // 8-bit bus, 2 lines, 5x8 font
      2'd1:    return 8'h0C;  // display on, cursor off
      2'd2:    return 8'h01;  // clear display
      default: return 8'h06;  // entry mode: increment, no shift
    endcase
  endfunction
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = last ? cnt_q : cnt_q - CW'(1);
    done_d      = 1'b0;
    lcd_on_d    = lcd_on_q;
    lcd_rs_d    = lcd_rs_q;
    lcd_data_d  = lcd_data_q;
`ifdef LCD_INIT_EN
    idx_d       = idx_q;
`endif
    // Pin strobes are registered decodes of the current state, so each pin
    // follows its state by one cycle and keeps the exact state duration.
    req_ready_d = (state_q == IDLE) && !hs;
    lcd_en_d    = (state_q == EN_HI);

    case (state_q)
      PWRUP: if (last) begin
`ifdef LCD_INIT_EN
        state_d = INIT_LOAD;
`else
        state_d = IDLE;
`endif
      end
`ifdef LCD_INIT_EN
      INIT_LOAD: begin
        lcd_on_d   = 1'b1;
        lcd_rs_d   = 1'b0;
        lcd_data_d = init_cmd(idx_q);
        state_d    = SETUP;
        cnt_d      = CW'(T_SETUP_CYC - 1);
      end
`endif
      IDLE: if (hs) begin
        lcd_on_d   = req_word[31];
        lcd_rs_d   = req_word[9];
        lcd_data_d = req_word[7:0];
        state_d    = SETUP;
        cnt_d      = CW'(T_SETUP_CYC - 1);
      end
      SETUP: if (last) begin
        state_d = EN_HI;
        cnt_d   = CW'(T_EN_CYC - 1);
      end
      EN_HI: if (last) begin
        state_d = HOLD;
        cnt_d   = CW'(T_HOLD_CYC - 1);
      end
      HOLD: if (last) begin
        state_d = EXEC;
        cnt_d   = is_clear ? CW'(T_CLEAR_CYC - 1) : CW'(T_EXEC_CYC - 1);
      end
      EXEC: if (last) begin
        done_d  = 1'b1;
        state_d = IDLE;
`ifdef LCD_INIT_EN
        // Index parks at the last entry once the sequence is finished, so
        // later software writes fall straight back to IDLE.
        if (idx_q != 2'd3) begin
          idx_d   = idx_q + 2'd1;
          state_d = INIT_LOAD;
        end
`endif
      end
      default: begin
        state_d = PWRUP;
        cnt_d   = CW'(T_PWRUP_CYC - 1);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PWRUP;
      cnt_q       <= CW'(T_PWRUP_CYC - 1);
      req_ready_q <= 1'b0;
      done_q      <= 1'b0;
      lcd_on_q    <= 1'b0;
      lcd_en_q    <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_data_q  <= 8'h00;
`ifdef LCD_INIT_EN
      idx_q       <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      done_q      <= done_d;
      lcd_on_q    <= lcd_on_d;
      lcd_en_q    <= lcd_en_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_data_q  <= lcd_data_d;
`ifdef LCD_INIT_EN
      idx_q       <= idx_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign lcd_on    = lcd_on_q;
  assign lcd_en    = lcd_en_q;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_data  = lcd_data_q;

endmodule

// File: tb/tb_lcd_cmd_engine.sv
// Directed bench for lcd_cmd_engine: power-up, single writes (data, clear,
// normal command), back-to-back handshake, reset during EN_HI, and the
// init sequence when LCD_INIT_EN is defined.
module tb_lcd_cmd_engine;
  localparam int TPU = 10;
  localparam int TS  = 3;
  localparam int TE  = 12;
  localparam int TH  = 3;
  localparam int TX  = 2500;
  localparam int TC  = 5000;
  localparam int WR  = TS + TE + TH;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_word = '0;
  logic        req_ready, busy, done, lcd_on, lcd_en, lcd_rs, lcd_rw;
  logic [7:0]  lcd_data;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int k, k2, n;

  lcd_cmd_engine #(
    .T_PWRUP_CYC(TPU), .T_SETUP_CYC(TS), .T_EN_CYC(TE),
    .T_HOLD_CYC(TH), .T_EXEC_CYC(TX), .T_CLEAR_CYC(TC)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_word(req_word), .busy(busy), .done(done), .lcd_on(lcd_on),
    .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reset edge, power-up wait, and (feature build) the init sequence.
  task automatic post_reset();
    int m, tr;
    logic [7:0] icmd [4];
    icmd = '{8'h38, 8'h0C, 8'h01, 8'h06};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_en", lcd_en, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_data", lcd_data, 0);
    chk("rst_on", lcd_on, 0);
    chk("rst_done", done, 0);
    chk("rst_rw", lcd_rw, 0);
    for (int i = 1; i <= TPU; i++) begin
      tick();
      chk("pwrup_ready", req_ready, 0);
      chk("pwrup_done", done, 0);
      chk("pwrup_en", lcd_en, 0);
      if (i < TPU) chk("pwrup_busy", busy, 1);
    end
`ifdef LCD_INIT_EN
    for (int e = 0; e < 4; e++) begin
      m = 0;
      while (!lcd_en && m < 200) begin tick(); m++; end
      tr = cyc;
      chk("init_rs", lcd_rs, 0);
      chk("init_data", lcd_data, icmd[e]);
      chk("init_on", lcd_on, 1);
      chk("init_ready", req_ready, 0);
      m = 0;
      while (!done && m < TC + 200) begin tick(); m++; end
      chk("init_exec", cyc - tr, TE + TH - 1 + ((e == 2) ? TC : TX));
      chk("init_ready_at_done", req_ready, 0);
      tick();
    end
    chk("init_ready_after", req_ready, 1);
`else
    tick();
    chk("pwrup_ready_rise", req_ready, 1);
    chk("pwrup_busy_low", busy, 0);
    chk("pwrup_on", lcd_on, 0);
`endif
  endtask

  task automatic send(input logic [31:0] w, output int ka);
    int m;
    req_valid = 1'b1;
    req_word  = w;
    m = 0;
    while (!req_ready && m < TC + 200) begin tick(); m++; end
    tick();
    ka = cyc;
    req_valid = 1'b0;
    chk("accept_ready_drop", req_ready, 0);
  endtask

  task automatic wait_done(input int ka, input int exp, input string tag);
    int m;
    m = 0;
    while (!done && m < TC + 200) begin tick(); m++; end
    chk(tag, cyc - ka, exp);
    tick();
    chk("done_pulse", done, 0);
    chk("ready_after_done", req_ready, 1);
  endtask

  initial begin
    post_reset();

    // Data write: ON, RS=1, 'A'
    send(32'h8000_0241, k);
    chk("w41_on", lcd_on, 1);
    chk("w41_rs", lcd_rs, 1);
    chk("w41_data", lcd_data, 8'h41);
    chk("w41_busy", busy, 1);
    chk("w41_en_setup", lcd_en, 0);
    n = 0;
    while (!lcd_en && n < 50) begin tick(); n++; end
    chk("w41_en_delay", cyc - k, TS + 1);
    n = 0;
    while (lcd_en && n < 50) begin tick(); n++; end
    chk("w41_en_width", n, TE);
    chk("w41_rs_hold", lcd_rs, 1);
    chk("w41_data_hold", lcd_data, 8'h41);
    wait_done(k, WR + TX, "w41_done_lat");

    // Clear / home boundaries and a normal command
    send(32'h0000_0001, k);
    chk("clr01_on", lcd_on, 0);
    chk("clr01_rs", lcd_rs, 0);
    wait_done(k, WR + TC, "clr01_exec");
    send(32'h0000_0080, k);
    chk("cmd80_data", lcd_data, 8'h80);
    wait_done(k, WR + TX, "cmd80_exec");
    send(32'h0000_0003, k);
    wait_done(k, WR + TC, "clr03_exec");
    send(32'h0000_0201, k);
    chk("d01_rs", lcd_rs, 1);
    wait_done(k, WR + TX, "d01_exec");

    // Back-to-back: valid held high across two words
    req_valid = 1'b1;
    req_word  = 32'h8000_0231;
    n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    tick();
    k = cyc;
    req_word = 32'h8000_0232;
    n = 0;
    while (!done && n < TC + 200) begin tick(); n++; end
    chk("b2b_first_done", cyc - k, WR + TX);
    chk("b2b_first_data", lcd_data, 8'h31);
    tick();
    chk("b2b_gap_ready", req_ready, 1);
    chk("b2b_gap_data", lcd_data, 8'h31);
    tick();
    chk("b2b_second_data", lcd_data, 8'h32);
    chk("b2b_second_ready", req_ready, 0);
    chk("b2b_second_at", cyc - k, WR + TX + 2);
    req_valid = 1'b0;
    k2 = cyc;
    wait_done(k2, WR + TX, "b2b_second_done");

    // Reset during EN_HI
    send(32'h8000_02AA, k);
    n = 0;
    while (!lcd_en && n < 50) begin tick(); n++; end
    tick(); tick(); tick();
    chk("abort_en_high", lcd_en, 1);
    post_reset();
    send(32'h8000_0255, k);
    chk("after_rst_data", lcd_data, 8'h55);
    chk("after_rst_on", lcd_on, 1);
    wait_done(k, WR + TX, "after_rst_done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
